// File: rtl/primus_instruction_decode.sv
// rtl/primus_instruction_decode.sv - Primus RV32I decode stage: register file, immediate generation, ID/EX pipeline register
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ir_i, npc_i, valid_i         instruction word, next PC and valid from fetch
//   stall_i, flush_i             hold / bubble control from hazard and branch logic
//   wb_we_i, wb_addr_i, wb_data_i  register file write port from write-back
//   ir_o, npc_o                  registered instruction word and next PC
//   rs1_data_o, rs2_data_o       registered operands
//   imm_o                        registered sign-extended immediate
//   rs1_addr_o, rs2_addr_o, rd_addr_o  registered register indices
//   valid_o, illegal_o           registered valid and unsupported-opcode flags

module primus_instruction_decode #(
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] npc_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] ir_o,
    output logic [31:0] npc_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        valid_o,
    output logic        illegal_o
);

    logic [31:0] rf_q [32];

    logic [31:0] ir_q, npc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic        valid_q, illegal_q;

    logic [4:0]  rs1_addr_d, rs2_addr_d, rd_addr_d;
    logic [31:0] rs1_data_d, rs2_data_d, imm_d;
    logic        legal_d;
    logic        wb_fire;

    assign rs1_addr_d = ir_i[19:15];
    assign rs2_addr_d = ir_i[24:20];
    assign rd_addr_d  = ir_i[11:7];

    // x0 is never written, so its entry stays at its reset value of zero.
    assign wb_fire = wb_we_i && (wb_addr_i != 5'd0);

    // Register file write port; independent of stall/flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_fire) begin
            rf_q[wb_addr_i] <= wb_data_i;
        end
    end

    // Same-cycle write-to-read bypass so a dependent decode needs no bubble.
    always_comb begin
        rs1_data_d = rf_q[rs1_addr_d];
        rs2_data_d = rf_q[rs2_addr_d];
        if (wb_fire && (wb_addr_i == rs1_addr_d)) rs1_data_d = wb_data_i;
        if (wb_fire && (wb_addr_i == rs2_addr_d)) rs2_data_d = wb_data_i;
    end

    // Immediate format selection. Every legal opcode ends in 2'b11, so a full
    // 7-bit match also rejects compressed/reserved low bits.
    always_comb begin
        imm_d   = '0;
        legal_d = 1'b1;
        case (ir_i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                imm_d = {{20{ir_i[31]}}, ir_i[31:20]};
            7'b0100011:
                imm_d = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            7'b1100011:
                imm_d = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm_d = {ir_i[31:12], 12'h000};
            7'b1101111:
                imm_d = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            7'b0110011, 7'b0001111:
                imm_d = '0;
            default: begin
                imm_d   = '0;
                legal_d = 1'b0;
            end
        endcase
    end

    // ID/EX pipeline register: flush beats stall beats load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_q       <= NOP_INSN;
            npc_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (flush_i) begin
            ir_q       <= NOP_INSN;
            npc_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (!stall_i) begin
            ir_q       <= ir_i;
            npc_q      <= npc_i;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            valid_q    <= valid_i;
            illegal_q  <= valid_i && !legal_d;
        end
    end

    assign ir_o       = ir_q;
    assign npc_o      = npc_q;
    assign rs1_data_o = rs1_data_q;
    assign rs2_data_o = rs2_data_q;
    assign imm_o      = imm_q;
    assign rs1_addr_o = rs1_addr_q;
    assign rs2_addr_o = rs2_addr_q;
    assign rd_addr_o  = rd_addr_q;
    assign valid_o    = valid_q;
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_primus_instruction_decode.sv
// tb/tb_primus_instruction_decode.sv - directed-vector bench for primus_instruction_decode

module tb_primus_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir_i, npc_i;
    logic        valid_i, stall_i, flush_i, wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic [31:0] ir_o, npc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        valid_o, illegal_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    primus_instruction_decode dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ir_i       (ir_i),
        .npc_i      (npc_i),
        .valid_i    (valid_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .ir_o       (ir_o),
        .npc_o      (npc_o),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .imm_o      (imm_o),
        .rs1_addr_o (rs1_addr_o),
        .rs2_addr_o (rs2_addr_o),
        .rd_addr_o  (rd_addr_o),
        .valid_o    (valid_o),
        .illegal_o  (illegal_o)
    );

    task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic v,
                         input logic st, input logic fl, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        ir_i = ir; npc_i = npc; valid_i = v; stall_i = st; flush_i = fl;
        wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick; tick;
        vectors++; if (ir_o !== 32'h00000013) begin miscompares++; $display("FAIL reset_ir: got %h want %h", ir_o, 32'h00000013); end
        vectors++; if ({npc_o, rs1_data_o, rs2_data_o, imm_o} !== 128'h0) begin miscompares++; $display("FAIL reset_data: got %h %h %h %h want 0", npc_o, rs1_data_o, rs2_data_o, imm_o); end
        vectors++; if ({rs1_addr_o, rs2_addr_o, rd_addr_o, valid_o, illegal_o} !== 17'h0) begin miscompares++; $display("FAIL reset_ctl: got %h want 0", {rs1_addr_o, rs2_addr_o, rd_addr_o, valid_o, illegal_o}); end
        #2 rst = 1'b0;
        // write x5, then decode ADD x1,x5,x0 to populate outputs
        drive(32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h11111111);
        tick;
        drive(32'h000280B3, 32'h00000204, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (rs1_data_o !== 32'h11111111) begin miscompares++; $display("FAIL pre_reset_rs1: got %h want %h", rs1_data_o, 32'h11111111); end
        // asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        vectors++; if (ir_o !== 32'h00000013 || valid_o !== 1'b0) begin miscompares++; $display("FAIL async_reset: got ir=%h v=%b want ir=00000013 v=0", ir_o, valid_o); end
        vectors++; if (rs1_data_o !== 32'h0) begin miscompares++; $display("FAIL async_reset_rs1: got %h want 0", rs1_data_o); end
        #1 rst = 1'b0;
        tick;
        vectors++; if (rs1_data_o !== 32'h0 || valid_o !== 1'b1) begin miscompares++; $display("FAIL rf_cleared: got rs1=%h v=%b want rs1=0 v=1", rs1_data_o, valid_o); end
    endtask

    task automatic test_write_read;
        drive(32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick;
        drive(32'h000280B3, 32'h00000104, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (rs1_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL add_rs1: got %h want %h", rs1_data_o, 32'hDEADBEEF); end
        vectors++; if (rs2_data_o !== 32'h0) begin miscompares++; $display("FAIL add_rs2: got %h want 0", rs2_data_o); end
        vectors++; if (rd_addr_o !== 5'd1 || rs1_addr_o !== 5'd5 || rs2_addr_o !== 5'd0) begin miscompares++; $display("FAIL add_addrs: got rd=%0d rs1=%0d rs2=%0d want 1 5 0", rd_addr_o, rs1_addr_o, rs2_addr_o); end
        vectors++; if (imm_o !== 32'h0 || npc_o !== 32'h00000104 || ir_o !== 32'h000280B3) begin miscompares++; $display("FAIL add_fields: got imm=%h npc=%h ir=%h", imm_o, npc_o, ir_o); end
        vectors++; if (valid_o !== 1'b1 || illegal_o !== 1'b0) begin miscompares++; $display("FAIL add_flags: got v=%b ill=%b want 1 0", valid_o, illegal_o); end
    endtask

    task automatic test_bypass;
        drive(32'hFFF38113, 32'h00000108, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h12345678);
        tick;
        vectors++; if (rs1_data_o !== 32'h12345678) begin miscompares++; $display("FAIL bypass_rs1: got %h want %h", rs1_data_o, 32'h12345678); end
        vectors++; if (imm_o !== 32'hFFFFFFFF || rd_addr_o !== 5'd2) begin miscompares++; $display("FAIL bypass_imm: got imm=%h rd=%0d want FFFFFFFF 2", imm_o, rd_addr_o); end
        // x7 now visible through the array
        drive(32'h000380B3, 32'h0000010C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (rs1_data_o !== 32'h12345678) begin miscompares++; $display("FAIL array_rs1: got %h want %h", rs1_data_o, 32'h12345678); end
        // write x0 alongside ADDI x2,x0,0: no bypass onto x0
        drive(32'h00000113, 32'h00000110, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h5);
        tick;
        vectors++; if (rs1_data_o !== 32'h0) begin miscompares++; $display("FAIL x0_bypass: got %h want 0", rs1_data_o); end
        drive(32'h00000113, 32'h00000114, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (rs1_data_o !== 32'h0) begin miscompares++; $display("FAIL x0_array: got %h want 0", rs1_data_o); end
    endtask

    task automatic test_immediates;
        logic [31:0] insn [4];
        logic [31:0] want [4];
        insn[0] = 32'hFE000EE3; want[0] = 32'hFFFFFFFC;  // BEQ x0,x0,-4
        insn[1] = 32'h0080006F; want[1] = 32'h00000008;  // JAL x0,+8
        insn[2] = 32'hABCDE0B7; want[2] = 32'hABCDE000;  // LUI x1
        insn[3] = 32'hFE112E23; want[3] = 32'hFFFFFFFC;  // SW x1,-4(x2)
        for (int i = 0; i < 4; i++) begin
            drive(insn[i], 32'h200 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            tick;
            vectors++; if (imm_o !== want[i] || valid_o !== 1'b1 || illegal_o !== 1'b0) begin miscompares++; $display("FAIL imm_%0d: got imm=%h v=%b ill=%b want imm=%h v=1 ill=0", i, imm_o, valid_o, illegal_o, want[i]); end
        end
        vectors++; if (rs1_addr_o !== 5'd2 || rs2_addr_o !== 5'd1 || rd_addr_o !== 5'd28) begin miscompares++; $display("FAIL sw_addrs: got rs1=%0d rs2=%0d rd=%0d want 2 1 28", rs1_addr_o, rs2_addr_o, rd_addr_o); end
    endtask

    task automatic test_stall_flush;
        drive(32'hABCDE0B7, 32'h00000300, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(32'hFE112E23, 32'h00000400, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'hCAFEF00D);
            tick;
            vectors++; if (ir_o !== 32'hABCDE0B7 || imm_o !== 32'hABCDE000 || npc_o !== 32'h00000300 || valid_o !== 1'b1 || rd_addr_o !== 5'd1) begin miscompares++; $display("FAIL stall_hold_%0d: got ir=%h imm=%h npc=%h v=%b rd=%0d", i, ir_o, imm_o, npc_o, valid_o, rd_addr_o); end
        end
        drive(32'hFE112E23, 32'h00000400, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (ir_o !== 32'h00000013 || valid_o !== 1'b0 || imm_o !== 32'h0 || npc_o !== 32'h0 || rd_addr_o !== 5'd0) begin miscompares++; $display("FAIL flush_stall: got ir=%h v=%b imm=%h npc=%h rd=%0d want 00000013 0 0 0 0", ir_o, valid_o, imm_o, npc_o, rd_addr_o); end
        // x2 written during the stall is now in the array
        drive(32'hFE112E23, 32'h00000404, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (rs1_data_o !== 32'hCAFEF00D || valid_o !== 1'b1) begin miscompares++; $display("FAIL post_stall_rs1: got %h v=%b want CAFEF00D 1", rs1_data_o, valid_o); end
    endtask

    task automatic test_illegal;
        drive(32'h00000000, 32'h00000500, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (illegal_o !== 1'b1 || imm_o !== 32'h0 || valid_o !== 1'b1) begin miscompares++; $display("FAIL illegal: got ill=%b imm=%h v=%b want 1 0 1", illegal_o, imm_o, valid_o); end
        drive(32'h00000000, 32'h00000504, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (illegal_o !== 1'b0 || valid_o !== 1'b0 || npc_o !== 32'h00000504) begin miscompares++; $display("FAIL illegal_invalid: got ill=%b v=%b npc=%h want 0 0 00000504", illegal_o, valid_o, npc_o); end
        // low bits 2'b10 with an otherwise-valid ADDI pattern
        drive(32'hFFF38112, 32'h00000508, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (illegal_o !== 1'b1 || imm_o !== 32'h0) begin miscompares++; $display("FAIL illegal_lowbits: got ill=%b imm=%h want 1 0", illegal_o, imm_o); end
        drive(32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick;
        vectors++; if (illegal_o !== 1'b0 || valid_o !== 1'b0) begin miscompares++; $display("FAIL illegal_flush: got ill=%b v=%b want 0 0", illegal_o, valid_o); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_bypass;
        test_immediates;
        test_stall_flush;
        test_illegal;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
